imm_gen_pipe: RTL
=================

# imm_gen_pipe

Parametrised, two-stage pipelined immediate generator for the datapath decode-to-execute path. It converts the 24-bit instruction immediate field into a DATA_W operand under a 3-bit mode select. It also produces rotated immediates with shifter carry-out, and PC-relative branch targets. Transfers use valid/ready handshakes on both sides, with stall and flush support.

## Interface
- DATA_W, 32: output operand width; legal values 32 or 64.
- BR_SHIFT, 2: left shift applied to the branch offset (word alignment).
- PC_OFFSET, 8: constant added to pc_in in branch-target mode (pipeline PC skew).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous; kills both stages.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  block can accept this cycle.
- imm_field  input  24  raw instruction immediate.
- imm_sel  input  3  mode select (see Operation).
- pc_in  input  DATA_W  PC of the instruction; used only in mode 4.
- out_valid  output  1  out_imm/out_carry/out_err valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  DATA_W  generated operand.
- out_carry  output  1  rotate carry-out (mode 3 only).
- out_err  output  1  undefined mode flag.

## Operation
- Modes, with sx = sign-extend and zx = zero-extend to DATA_W; all arithmetic is modulo 2^DATA_W:
  - 0: zx(imm_field[7:0]).
  - 1: zx(imm_field[11:0]).
  - 2: sx(imm_field[23:0]) << BR_SHIFT.
  - 3: zx(imm_field[7:0]) rotated right by 2*imm_field[11:8] within DATA_W.
  - 4: pc_in + PC_OFFSET + (sx(imm_field[23:0]) << BR_SHIFT).
  - 5: sx(imm_field[11:0]).
  - 6, 7: undefined; out_imm = 0, out_err = 1.
- out_carry = result[DATA_W-1] in mode 3 when the rotate amount is nonzero; 0 in all other cases.
- Stage 1 (S1) registers:
  - mode;
  - extended base value: imm8 for mode 3, shifted offset for modes 2/4, final value for 0/1/5;
  - rotate amount;
  - pc_in + PC_OFFSET;
  - valid bit s1_v.
- Stage 2 (S2) registers:
  - the rotate result (mode 3) or the add result (mode 4); other modes pass through;
  - carry and err;
  - valid bit s2_v.
- out_valid = s2_v. Output registers are driven directly; there is no combinational path from inputs to outputs.
- Advance rules:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv && !flush.
- S2 loads S1 when s1_v && s2_adv. If S2 is drained with no S1 data (out_ready && !s1_v), s2_v clears.
- A stalled stage holds all of its registers unchanged. out_imm stays stable while out_valid && !out_ready.
- Undefined mode does not stall. The transaction flows through with out_err = 1.

## Timing
- Reset (rst_n low, asynchronous): s1_v = s2_v = 0, out_imm = 0, out_carry = 0, out_err = 0, in_ready = 1 after reset deassertion (forced 0 only by flush).
- Latency: an input accepted in cycle N appears on the outputs in cycle N+2 when there is no stall.
- Throughput: one result per cycle under continuous out_ready.
- Full condition: s1_v && s2_v && !out_ready. In this state in_ready = 0 and nothing changes.
- Simultaneous accept and drain: with out_ready = 1 and both stages full, S2 takes S1 and S1 takes the new input in the same edge. No bubble is inserted.
- flush has priority over all advances. On the next edge s1_v = s2_v = 0. The in_valid transfer offered that cycle is not accepted (in_ready = 0). Data registers may hold stale values, but out_valid = 0.
- Reset asserted mid-transaction discards all in-flight results. No partial output is produced.
- Wrap-around: mode 4 sums and mode 2 shifts truncate silently; there is no overflow flag.

## Test plan
- Reset and idle: hold rst_n = 0 with in_valid = 1 → out_valid = 0, out_imm = 0. Release reset → in_ready = 1.
- Modes 0/1/2/5, one beat each with out_ready = 1 and imm_field = 0x800FFF:
  - mode 0 → 0x000000FF.
  - mode 1 → 0x00000FFF.
  - mode 2 → 0xFE003FFC.
  - mode 5 → 0xFFFFFFFF.
  - Each result appears 2 cycles after acceptance.
- Rotate (mode 3), DATA_W = 32:
  - imm_field[11:0] = 0x10F → out_imm 0xC0000003, out_carry 1.
  - imm_field[11:0] = 0x0FF → out_imm 0xFF, out_carry 0.
- Branch target (mode 4): pc_in = 0x100, imm_field = 0xFFFFFE → out_imm 0x100. Second case: pc_in = 0xFFFFFFFC, imm_field = 0x000001 → out_imm 0x00000008 (wrap-around).
- Backpressure: stream 4 transactions with out_ready = 0 for 3 cycles →
  - in_ready drops after 2 accepts;
  - out_imm stays stable during the stall;
  - all 4 results emerge in order, with no loss or duplication, once out_ready = 1.
- Flush and undefined mode:
  - Flush with both stages full → out_valid = 0 next cycle, and the concurrent input is not accepted.
  - Then send imm_sel = 7 → out_imm 0, out_err 1, out_valid 1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Two-stage pipelined immediate generator for the decode-to-execute path.
//   Converts the 24-bit instruction immediate field into a DATA_W operand
//   under a 3-bit mode select. It also produces rotated immediates with
//   shifter carry-out and PC-relative branch targets.
//
//   Modes (sx = sign-extend, zx = zero-extend, all arithmetic mod 2^DATA_W):
//     0: zx(imm[7:0])            1: zx(imm[11:0])
//     2: sx(imm[23:0]) << BR_SHIFT
//     3: zx(imm[7:0]) ror 2*imm[11:8], out_carry = msb when amount != 0
//     4: pc_in + PC_OFFSET + (sx(imm[23:0]) << BR_SHIFT)
//     5: sx(imm[11:0])           6,7: out_imm = 0, out_err = 1
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of both stages
//   in_valid/in_ready upstream handshake (imm_field, imm_sel, pc_in)
//   out_valid/out_ready downstream handshake (out_imm, out_carry, out_err)
//
// S1 holds the decoded base value, rotate amount and pc_in + PC_OFFSET.
// S2 performs the rotate or add and drives the output registers directly.
module imm_gen_pipe #(
  parameter int DATA_W    = 32,
  parameter int BR_SHIFT  = 2,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       imm_field,
  input  logic [2:0]        imm_sel,
  input  logic [DATA_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_carry,
  output logic              out_err
);

  localparam int AMT_W = $clog2(DATA_W);

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] zx8(input logic [7:0] v);
    zx8 = {{(DATA_W-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zx12(input logic [11:0] v);
    zx12 = {{(DATA_W-12){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sx12(input logic [11:0] v);
    sx12 = {{(DATA_W-12){v[11]}}, v};
  endfunction

  // Sign-extended branch offset scaled to word alignment; upper bits fall off.
  function automatic logic [DATA_W-1:0] br_off(input logic [23:0] v);
    logic [DATA_W-1:0] ext;
    ext    = {{(DATA_W-24){v[23]}}, v};
    br_off = ext << BR_SHIFT;
  endfunction

  // Rotate right within DATA_W. The left shift uses the AMT_W-bit two's
  // complement of the amount, which is 0 when a is 0, so no shift by
  // DATA_W is ever needed (DATA_W is a power of two).
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] v,
                                            input logic [AMT_W-1:0]  a);
    logic [AMT_W-1:0] l;
    l   = (~a) + {{(AMT_W-1){1'b0}}, 1'b1};
    ror = (v >> a) | (v << l);
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_v_r;
  logic s2_v_r;
  logic s1_adv_s;
  logic s2_adv_s;
  logic accept_s;

  assign s2_adv_s  = !s2_v_r || out_ready;
  assign s1_adv_s  = !s1_v_r || s2_adv_s;
  assign in_ready  = s1_adv_s && !flush;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = s2_v_r;

  // ---------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------
  logic [2:0]        s1_mode_r;
  logic [DATA_W-1:0] s1_base_r;
  logic [AMT_W-1:0]  s1_amt_r;
  logic [DATA_W-1:0] s1_pc_r;

  logic [DATA_W-1:0] base_s;
  logic [AMT_W-1:0]  amt_s;
  logic [DATA_W-1:0] pc_s;

  // Decode the immediate into the base value that S2 finishes.
  always_comb begin
    base_s = {DATA_W{1'b0}};
    amt_s  = AMT_W'({imm_field[11:8], 1'b0});
    pc_s   = pc_in + DATA_W'(PC_OFFSET);
    case (imm_sel)
      3'd0, 3'd3: base_s = zx8(imm_field[7:0]);
      3'd1:       base_s = zx12(imm_field[11:0]);
      3'd2, 3'd4: base_s = br_off(imm_field);
      3'd5:       base_s = sx12(imm_field[11:0]);
      default:    base_s = {DATA_W{1'b0}};
    endcase
  end

  // S1 register: loads on accept, holds while stalled, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r    <= 1'b0;
      s1_mode_r <= 3'd0;
      s1_base_r <= {DATA_W{1'b0}};
      s1_amt_r  <= {AMT_W{1'b0}};
      s1_pc_r   <= {DATA_W{1'b0}};
    end else if (flush) begin
      s1_v_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        s1_mode_r <= imm_sel;
        s1_base_r <= base_s;
        s1_amt_r  <= amt_s;
        s1_pc_r   <= pc_s;
      end else begin
        s1_mode_r <= s1_mode_r;
      end
    end else begin
      s1_v_r <= s1_v_r;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rot_s;
  logic [DATA_W-1:0] s2_imm_s;
  logic              s2_carry_s;
  logic              s2_err_s;

  assign rot_s = ror(s1_base_r, s1_amt_r);

  // Finish the operand: rotate for mode 3, add for mode 4, pass others.
  always_comb begin
    s2_imm_s   = s1_base_r;
    s2_carry_s = 1'b0;
    s2_err_s   = 1'b0;
    case (s1_mode_r)
      3'd3: begin
        s2_imm_s = rot_s;
        if (s1_amt_r != {AMT_W{1'b0}}) begin
          s2_carry_s = rot_s[DATA_W-1];
        end else begin
          s2_carry_s = 1'b0;
        end
      end
      3'd4:       s2_imm_s = s1_pc_r + s1_base_r;
      3'd6, 3'd7: begin
        s2_imm_s = {DATA_W{1'b0}};
        s2_err_s = 1'b1;
      end
      default:    s2_imm_s = s1_base_r;
    endcase
  end

  // S2 / output registers: load from S1 when advancing, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_r    <= 1'b0;
      out_imm   <= {DATA_W{1'b0}};
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (flush) begin
      s2_v_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        out_imm   <= s2_imm_s;
        out_carry <= s2_carry_s;
        out_err   <= s2_err_s;
      end else begin
        out_imm   <= out_imm;
      end
    end else begin
      s2_v_r <= s2_v_r;
    end
  end

endmodule
